// File: rtl/ucsbece154b_mem_arbiter_if.sv
// Shared-memory arbiter bus: icache refill port, data port, memory port and perf counters.
// The slave modport is the arbiter's view; master is the clients-plus-memory view.
interface ucsbece154b_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  IMemReadRequest;
  logic [ADDR_WIDTH-1:0] IMemReadAddress;
  logic [DATA_WIDTH-1:0] IMemDataIn;
  logic                  IMemDataReady;

  logic                  DMemRequest;
  logic                  DMemWrite;
  logic [ADDR_WIDTH-1:0] DMemAddress;
  logic [DATA_WIDTH-1:0] DMemWriteData;
  logic [DATA_WIDTH-1:0] DMemReadData;
  logic                  DMemDone;

  logic                  MemReadRequest;
  logic                  MemWriteRequest;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] MemWriteData;
  logic [DATA_WIDTH-1:0] MemDataIn;
  logic                  MemDataReady;

  logic [1:0]            Grant;
  logic [31:0]           IGrantCount;
  logic [31:0]           DGrantCount;
  logic [31:0]           ConflictCount;

  modport slave (
    input  IMemReadRequest, IMemReadAddress,
    output IMemDataIn, IMemDataReady,
    input  DMemRequest, DMemWrite, DMemAddress, DMemWriteData,
    output DMemReadData, DMemDone,
    output MemReadRequest, MemWriteRequest, MemAddress, MemWriteData,
    input  MemDataIn, MemDataReady,
    output Grant, IGrantCount, DGrantCount, ConflictCount
  );

  modport master (
    output IMemReadRequest, IMemReadAddress,
    input  IMemDataIn, IMemDataReady,
    output DMemRequest, DMemWrite, DMemAddress, DMemWriteData,
    input  DMemReadData, DMemDone,
    input  MemReadRequest, MemWriteRequest, MemAddress, MemWriteData,
    output MemDataIn, MemDataReady,
    input  Grant, IGrantCount, DGrantCount, ConflictCount
  );
endinterface

// File: rtl/ucsbece154b_mem_arbiter.sv
// Round-robin arbiter serialising icache burst refills and single-word data accesses
// onto one memory bus, with grant/conflict performance counters.
module ucsbece154b_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 4
) (
  input logic clk,
  input logic reset,
  ucsbece154b_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int unsigned OFF_W = CNT_W + 2;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_I_BURST = 2'd1,
    S_D_READ  = 2'd2,
    S_D_WRITE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_word_cnt;
  logic                  r_last_d;
  logic                  r_mem_rd;
  logic                  r_mem_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:0]           r_igrant;
  logic [31:0]           r_dgrant;
  logic [31:0]           r_conflict;

  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_conflict;
  logic                  w_last_word;
  logic [DATA_WIDTH-1:0] w_imem_data;
  logic                  w_imem_rdy;
  logic [DATA_WIDTH-1:0] w_dmem_data;
  logic                  w_dmem_done;
  logic [1:0]            w_grant;

  assign w_last_word = bus.MemDataReady && (r_word_cnt == LAST_WORD);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and arbitration; on a tie the requester not served last wins
  always_comb begin
    w_next     = r_state;
    w_grant_i  = 1'b0;
    w_grant_d  = 1'b0;
    w_conflict = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.IMemReadRequest && bus.DMemRequest) begin
          w_conflict = 1'b1;
          w_grant_i  = r_last_d;
          w_grant_d  = !r_last_d;
        end else begin
          w_grant_i = bus.IMemReadRequest;
          w_grant_d = bus.DMemRequest;
        end
        if (w_grant_i)      w_next = S_I_BURST;
        else if (w_grant_d) w_next = bus.DMemWrite ? S_D_WRITE : S_D_READ;
      end
      S_I_BURST: if (w_last_word)      w_next = S_IDLE;
      S_D_READ:  if (bus.MemDataReady) w_next = S_IDLE;
      S_D_WRITE: if (bus.MemDataReady) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Response steering: only the owner of the bus sees memory data and pulses
  always_comb begin
    w_imem_data = '0;
    w_imem_rdy  = 1'b0;
    w_dmem_data = '0;
    w_dmem_done = 1'b0;
    w_grant     = 2'b00;
    case (r_state)
      S_I_BURST: begin
        w_grant     = 2'b01;
        w_imem_data = bus.MemDataIn;
        w_imem_rdy  = bus.MemDataReady;
      end
      S_D_READ: begin
        w_grant     = 2'b10;
        w_dmem_data = bus.MemDataIn;
        w_dmem_done = bus.MemDataReady;
      end
      S_D_WRITE: begin
        w_grant     = 2'b10;
        w_dmem_done = bus.MemDataReady;
      end
      default: ;
    endcase
  end

  // Transaction latches, memory request flags, burst word counter and perf counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word_cnt <= '0;
      r_last_d   <= 1'b1;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_igrant   <= '0;
      r_dgrant   <= '0;
      r_conflict <= '0;
    end else begin
      r_mem_rd <= (w_next == S_I_BURST) || (w_next == S_D_READ);
      r_mem_wr <= (w_next == S_D_WRITE);
      if (w_grant_i) begin
        r_addr   <= bus.IMemReadAddress & ALIGN_MASK;
        r_last_d <= 1'b0;
        r_igrant <= r_igrant + 32'd1;
      end
      if (w_grant_d) begin
        r_addr   <= bus.DMemAddress;
        r_wdata  <= bus.DMemWriteData;
        r_last_d <= 1'b1;
        r_dgrant <= r_dgrant + 32'd1;
      end
      if (w_conflict) r_conflict <= r_conflict + 32'd1;
      if ((r_state == S_I_BURST) && bus.MemDataReady)
        r_word_cnt <= w_last_word ? '0 : r_word_cnt + CNT_W'(1);
    end
  end

  assign bus.IMemDataIn      = w_imem_data;
  assign bus.IMemDataReady   = w_imem_rdy;
  assign bus.DMemReadData    = w_dmem_data;
  assign bus.DMemDone        = w_dmem_done;
  assign bus.MemReadRequest  = r_mem_rd;
  assign bus.MemWriteRequest = r_mem_wr;
  assign bus.MemAddress      = r_addr;
  assign bus.MemWriteData    = r_wdata;
  assign bus.Grant           = w_grant;
  assign bus.IGrantCount     = r_igrant;
  assign bus.DGrantCount     = r_dgrant;
  assign bus.ConflictCount   = r_conflict;

endmodule

// File: tb/tb_ucsbece154b_mem_arbiter.sv
// Directed bench for the memory arbiter: stimulus pushes expected response words into
// queues, a negedge monitor pops them whenever the DUT pulses a response.
module tb_ucsbece154b_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ucsbece154b_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ucsbece154b_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BLOCK_WORDS(BW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] exp_ig = 0, exp_dg = 0, exp_cf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the next queued expectation
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (bus.IMemDataReady === 1'b1) begin
      if (iq.size() == 0) begin
        checks++; errors++;
        $display("FAIL imem_unexpected: got pulse with 0x%08h expected no pulse at %0t", bus.IMemDataIn, $time);
      end else begin
        e = iq.pop_front();
        chk("imem_word", bus.IMemDataIn, e);
      end
    end
    if (bus.DMemDone === 1'b1) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL dmem_unexpected: got done with 0x%08h expected no done at %0t", bus.DMemReadData, $time);
      end else begin
        e = dq.pop_front();
        chk("dmem_data", bus.DMemReadData, e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.IMemReadRequest = 1'b0;
    bus.IMemReadAddress = '0;
    bus.DMemRequest     = 1'b0;
    bus.DMemWrite       = 1'b0;
    bus.DMemAddress     = '0;
    bus.DMemWriteData   = '0;
    bus.MemDataIn       = '0;
    bus.MemDataReady    = 1'b0;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_igrant"},   bus.IGrantCount,   exp_ig);
    chk({tag, "_dgrant"},   bus.DGrantCount,   exp_dg);
    chk({tag, "_conflict"}, bus.ConflictCount, exp_cf);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    exp_ig = 0; exp_dg = 0; exp_cf = 0;
    reset = 1'b1;
  endtask

  // Memory returns a full refill burst on consecutive cycles
  task automatic burst(input logic [31:0] base);
    for (int i = 0; i < int'(BW); i++) begin
      bus.MemDataReady = 1'b1;
      bus.MemDataIn    = base + 32'(i);
      iq.push_back(base + 32'(i));
      @(negedge clk);
      chk("burst_grant", 32'(bus.Grant), 32'h1);
      chk("burst_dport_quiet", bus.DMemReadData, 32'h0);
      tick();
    end
    bus.MemDataReady = 1'b0;
    bus.MemDataIn    = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    idle_inputs();
    tick(); tick();
    @(negedge clk);
    chk("rst_grant", 32'(bus.Grant), 32'h0);
    chk("rst_rdreq", 32'(bus.MemReadRequest), 32'h0);
    chk("rst_wrreq", 32'(bus.MemWriteRequest), 32'h0);
    chk("rst_addr", bus.MemAddress, 32'h0);
    chk("rst_wdata", bus.MemWriteData, 32'h0);
    chk_counts("rst");
    tick();
    reset = 1'b1;

    // Icache-only refill with block alignment
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0001_0014;
    @(negedge clk);
    chk("t1_grant_latency", 32'(bus.Grant), 32'h0);
    tick(); exp_ig++;
    @(negedge clk);
    chk("t1_grant", 32'(bus.Grant), 32'h1);
    chk("t1_rdreq", 32'(bus.MemReadRequest), 32'h1);
    chk("t1_wrreq", 32'(bus.MemWriteRequest), 32'h0);
    chk("t1_addr", bus.MemAddress, 32'h0001_0010);
    tick();
    burst(32'hA0);
    bus.IMemReadRequest = 1'b0;
    @(negedge clk);
    chk("t1_idle_grant", 32'(bus.Grant), 32'h0);
    chk("t1_idle_rdreq", 32'(bus.MemReadRequest), 32'h0);
    chk_counts("t1");
    tick();

    // Data write acknowledged on the third cycle
    bus.DMemRequest   = 1'b1;
    bus.DMemWrite     = 1'b1;
    bus.DMemAddress   = 32'h1000_0070;
    bus.DMemWriteData = 32'hBEEF_0000;
    tick(); exp_dg++;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) begin
        bus.MemDataReady = 1'b1;
        dq.push_back(32'h0);
      end
      @(negedge clk);
      chk("t2_wrreq", 32'(bus.MemWriteRequest), 32'h1);
      chk("t2_rdreq", 32'(bus.MemReadRequest), 32'h0);
      chk("t2_wdata", bus.MemWriteData, 32'hBEEF_0000);
      chk("t2_addr", bus.MemAddress, 32'h1000_0070);
      chk("t2_grant", 32'(bus.Grant), 32'h2);
      tick();
    end
    bus.MemDataReady = 1'b0;
    bus.DMemRequest  = 1'b0;
    bus.DMemWrite    = 1'b0;
    @(negedge clk);
    chk("t2_end_wrreq", 32'(bus.MemWriteRequest), 32'h0);
    chk("t2_end_rdreq", 32'(bus.MemReadRequest), 32'h0);
    chk_counts("t2");
    tick();

    // Simultaneous requests out of reset: icache first, then data on the second tie
    do_reset();
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0000_0044;
    bus.DMemRequest     = 1'b1;
    bus.DMemWrite       = 1'b0;
    bus.DMemAddress     = 32'h0000_0100;
    tick(); exp_ig++; exp_cf++;
    @(negedge clk);
    chk("t3_first_grant", 32'(bus.Grant), 32'h1);
    chk("t3_addr_i", bus.MemAddress, 32'h0000_0040);
    chk_counts("t3a");
    tick();
    burst(32'hC0);
    @(negedge clk);
    chk("t3_gap_grant", 32'(bus.Grant), 32'h0);
    chk("t3_gap_rdreq", 32'(bus.MemReadRequest), 32'h0);
    tick(); exp_dg++; exp_cf++;
    @(negedge clk);
    chk("t3_second_grant", 32'(bus.Grant), 32'h2);
    chk("t3_addr_d", bus.MemAddress, 32'h0000_0100);
    chk("t3_rdreq", 32'(bus.MemReadRequest), 32'h1);
    chk_counts("t3b");
    tick();
    bus.MemDataReady = 1'b1;
    bus.MemDataIn    = 32'h1234_5678;
    dq.push_back(32'h1234_5678);
    tick();
    bus.MemDataReady    = 1'b0;
    bus.MemDataIn       = '0;
    bus.IMemReadRequest = 1'b0;
    bus.DMemRequest     = 1'b0;
    @(negedge clk);
    chk("t3_end_grant", 32'(bus.Grant), 32'h0);
    chk_counts("t3c");
    tick();

    // Data read arriving mid-burst waits for the burst to finish
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0000_0208;
    tick(); exp_ig++;
    @(negedge clk);
    chk("t4_grant_i", 32'(bus.Grant), 32'h1);
    chk("t4_addr_i", bus.MemAddress, 32'h0000_0200);
    tick();
    bus.DMemRequest = 1'b1;
    bus.DMemWrite   = 1'b0;
    bus.DMemAddress = 32'h0000_0300;
    burst(32'hB0);
    bus.IMemReadRequest = 1'b0;
    @(negedge clk);
    chk("t4_gap_grant", 32'(bus.Grant), 32'h0);
    tick(); exp_dg++;
    @(negedge clk);
    chk("t4_grant_d", 32'(bus.Grant), 32'h2);
    chk("t4_addr_d", bus.MemAddress, 32'h0000_0300);
    tick();
    tick();
    bus.MemDataReady = 1'b1;
    bus.MemDataIn    = 32'hCAFE_F00D;
    dq.push_back(32'hCAFE_F00D);
    tick();
    bus.MemDataReady = 1'b0;
    bus.MemDataIn    = '0;
    bus.DMemRequest  = 1'b0;
    @(negedge clk);
    chk_counts("t4");
    tick();

    // Stray memory pulses while idle are ignored
    bus.MemDataReady = 1'b1;
    bus.MemDataIn    = 32'hDEAD_0001;
    @(negedge clk);
    chk("t5_grant", 32'(bus.Grant), 32'h0);
    tick();
    bus.MemDataIn = 32'hDEAD_0002;
    tick();
    bus.MemDataReady = 1'b0;
    bus.MemDataIn    = '0;
    @(negedge clk);
    chk("t5_rdreq", 32'(bus.MemReadRequest), 32'h0);
    chk_counts("t5");
    tick();

    // Reset after the second burst word drops the transaction
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0000_0400;
    tick(); exp_ig++;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.MemDataReady = 1'b1;
      bus.MemDataIn    = 32'hE0 + 32'(i);
      iq.push_back(32'hE0 + 32'(i));
      tick();
    end
    reset               = 1'b0;
    bus.MemDataReady    = 1'b0;
    bus.IMemReadRequest = 1'b0;
    tick();
    exp_ig = 0; exp_dg = 0; exp_cf = 0;
    @(negedge clk);
    chk("t6_grant", 32'(bus.Grant), 32'h0);
    chk("t6_rdreq", 32'(bus.MemReadRequest), 32'h0);
    chk("t6_wrreq", 32'(bus.MemWriteRequest), 32'h0);
    chk("t6_addr", bus.MemAddress, 32'h0);
    chk_counts("t6");
    tick();
    reset            = 1'b1;
    bus.MemDataReady = 1'b1;
    bus.MemDataIn    = 32'hE0E0_0003;
    @(negedge clk);
    chk("t6_stray_grant", 32'(bus.Grant), 32'h0);
    tick();
    tick();
    bus.MemDataReady  = 1'b0;
    bus.MemDataIn     = '0;
    bus.DMemRequest   = 1'b1;
    bus.DMemWrite     = 1'b1;
    bus.DMemAddress   = 32'h0000_0080;
    bus.DMemWriteData = 32'h55AA_55AA;
    tick(); exp_dg++;
    @(negedge clk);
    chk("t6_grant_d", 32'(bus.Grant), 32'h2);
    chk("t6_wrreq_new", 32'(bus.MemWriteRequest), 32'h1);
    chk("t6_wdata", bus.MemWriteData, 32'h55AA_55AA);
    tick();
    bus.MemDataReady = 1'b1;
    dq.push_back(32'h0);
    tick();
    bus.MemDataReady = 1'b0;
    bus.DMemRequest  = 1'b0;
    bus.DMemWrite    = 1'b0;
    @(negedge clk);
    chk_counts("t6b");
    tick();

    // Full burst after reset confirms the word counter restarted
    bus.IMemReadRequest = 1'b1;
    bus.IMemReadAddress = 32'h0000_050C;
    tick(); exp_ig++;
    @(negedge clk);
    chk("t7_grant", 32'(bus.Grant), 32'h1);
    chk("t7_addr", bus.MemAddress, 32'h0000_0500);
    tick();
    burst(32'hD0);
    bus.IMemReadRequest = 1'b0;
    @(negedge clk);
    chk("t7_idle_grant", 32'(bus.Grant), 32'h0);
    chk_counts("t7");
    tick();
    tick();

    chk("iq_drained", 32'(iq.size()), 32'h0);
    chk("dq_drained", 32'(dq.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ucsbece154b_mem_arbiter.md
# ucsbece154b_mem_arbiter

Two-port arbiter that shares the single main-memory bus between the instruction cache refill port and the data memory port. It sits between the icache and dmem request interfaces and the memory model. It serialises whole transactions: a BLOCK_WORDS burst read for the icache, or a single-word read/write for data. Ties are broken round-robin, and grant/conflict counters are kept for the performance bench.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- BLOCK_WORDS, 4, words per icache refill burst (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; low at a rising edge resets all state
- IMemReadRequest  in  1  icache refill request (level, held until burst done)
- IMemReadAddress  in  ADDR_WIDTH  refill address (arbiter block-aligns it)
- IMemDataIn  out  DATA_WIDTH  refill word to icache
- IMemDataReady  out  1  one-cycle pulse per valid refill word
- DMemRequest  in  1  data request (level, held until DMemDone)
- DMemWrite  in  1  1 = write, 0 = read; sampled at grant
- DMemAddress  in  ADDR_WIDTH  data word address
- DMemWriteData  in  DATA_WIDTH  write data; sampled at grant
- DMemReadData  out  DATA_WIDTH  read data to data port
- DMemDone  out  1  one-cycle pulse: read data valid or write acknowledged
- MemReadRequest  out  1  read request to memory, held through transaction
- MemWriteRequest  out  1  write request to memory, held through transaction
- MemAddress  out  ADDR_WIDTH  latched transaction address
- MemWriteData  out  DATA_WIDTH  latched write data
- MemDataIn  in  DATA_WIDTH  memory return data
- MemDataReady  in  1  memory pulse: one per returned read word, or one write ack
- Grant  out  2  01 = icache owns bus, 10 = data owns bus, 00 = idle
- IGrantCount, DGrantCount, ConflictCount  out  32 each  wrapping transaction/tie counters

## Operation
- States: IDLE, I_BURST, D_READ, D_WRITE.
- IDLE decisions:
  - Only IMemReadRequest high -> I_BURST.
  - Only DMemRequest high -> D_WRITE if DMemWrite, else D_READ.
  - Both high -> grant the requester opposite LastGrant, and ConflictCount += 1.
- On each grant:
  - Latch the address, write data and write flag.
  - Update LastGrant.
  - Increment IGrantCount or DGrantCount.
- Icache address is block-aligned: low log2(BLOCK_WORDS)+2 bits are forced to 0.
- I_BURST:
  - MemReadRequest = 1.
  - IMemDataIn = MemDataIn and IMemDataReady = MemDataReady (combinational pass-through).
  - Word counter increments on each MemDataReady.
  - On the BLOCK_WORDS-th pulse: counter clears and next state is IDLE.
- D_READ: MemReadRequest = 1. On the MemDataReady pulse: DMemReadData = MemDataIn, DMemDone = 1, next state IDLE.
- D_WRITE: MemWriteRequest = 1, MemWriteData = latched data. On the MemDataReady pulse: DMemDone = 1, next state IDLE.
- Outside its owning state, IMemDataReady and DMemDone are 0; IMemDataIn and DMemReadData are 0 when not owner.
- MemDataReady while in IDLE is ignored: no pulses forwarded, no counter change.
- A requester dropping its request mid-transaction does not abort it; the transaction completes and the response pulse is still issued.
- Mem*Request, MemAddress and MemWriteData are registered outputs driven from state and latches; they are constant through a transaction.
- Grant decodes the current state.
- Counters wrap modulo 2^32.

## Timing
- Reset (reset = 0 at an edge):
  - State = IDLE, LastGrant = data (icache wins the first tie).
  - Word counter 0; all outputs and counters 0.
  - Applies from any state, including mid-burst; the in-flight transaction is dropped.
- Request high at edge k in IDLE -> Grant and Mem*Request high after edge k (cycle k+1). Arbitration latency is 1 cycle.
- Final MemDataReady in cycle m:
  - Response pulse is in cycle m.
  - State is IDLE after edge m, and Mem*Request is low in cycle m+1.
  - Earliest next grant is after edge m+1, so there is a minimum one-cycle idle gap between transactions.
- A request still high in cycle m+1 (the done-cycle re-assert case) is arbitrated normally at edge m+1. With both requesting, the other requester wins.
- Back-to-back MemDataReady pulses (every cycle) are accepted during a burst; the burst minimum is BLOCK_WORDS cycles.

## Test plan
- Icache-only refill, address 0x0001_0014, memory returns words 0xA0..0xA3 on 4 consecutive cycles -> MemAddress = 0x0001_0010; four IMemDataReady pulses carrying 0xA0..0xA3; IDLE after the 4th; IGrantCount = 1.
- Data write 0xBEEF_0000 to 0x1000_0070, ack after 3 cycles -> MemWriteRequest high for 3 cycles, MemWriteData = 0xBEEF_0000; DMemDone pulses once; MemReadRequest never high.
- Simultaneous I and D requests out of reset, both held -> icache granted first (burst completes), one idle cycle, then data granted; ConflictCount = 2 if both keep re-requesting through a second tie, and Grant then alternates.
- Data read issued while a burst is active -> data waits; no DMemDone until its own MemDataReady; DMemReadData matches MemDataIn at that pulse, and the burst words are not seen on the data port.
- Stray MemDataReady pulse while IDLE -> no output pulses, counters unchanged.
- reset driven low after the 2nd word of a burst -> next cycle IDLE, all outputs 0, counters 0; remaining MemDataReady pulses ignored; a new request is granted normally after release.
